// File: rtl/m_mem_unit_if.sv
// Valid/ready data bus between the M-stage memory unit and the bridge.
// The master drives the request side; the slave answers with ready and read data.
interface m_mem_unit_if;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byteen;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_addr, bus_wdata, bus_byteen,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_addr, bus_wdata, bus_byteen,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/m_mem_unit.sv
// M-stage memory access unit: load/store -> valid/ready bus request, lane steering,
// load extension, AdEL/AdES detection and pipeline stall. Optional macro: M_MEM_TIMEOUT_EN.
module m_mem_unit #(
  parameter logic [31:0] DM_END      = 32'h0000_2FFF,
  parameter logic [31:0] TC0_BASE    = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE    = 32'h0000_7F10,
  parameter logic [31:0] INT_BASE    = 32'h0000_7F20,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               m_load,
  input  logic               m_store,
  input  logic [1:0]         m_size,
  input  logic               m_sext,
  input  logic [31:0]        m_addr,
  input  logic [31:0]        m_wdata,
  m_mem_unit_if.master       bus,
  output logic [31:0]        m_rdata,
  output logic               m_stall,
  output logic               m_exc,
  output logic [4:0]         m_exccode
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
`ifdef M_MEM_TIMEOUT_EN
  localparam logic [4:0] EXC_DBE  = 5'd7;
`endif

  state_t state_q, state_d;

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    if (size[1])      return word;
    else if (size[0]) return {{16{sext & h[15]}}, h};
    else              return {{24{sext & b[7]}}, b};
  endfunction

  logic        is_mem, is_store;
  logic        misalign, in_dm, in_tc0, in_tc1, in_int, in_io;
  logic        narrow_io, count_st, addr_exc, access;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic        latch_en;

  // Held copy of the request while a slow slave is working on it.
  logic [31:0] addr_p1, wdata_p1;
  logic [3:0]  byteen_p1;
  logic [1:0]  lane_p1, size_p1;
  logic        sext_p1, load_p1;

  assign is_mem   = m_load | m_store;
  assign is_store = m_store;

  assign misalign  = ((m_size == 2'd1) & m_addr[0]) | (m_size[1] & (|m_addr[1:0]));
  assign in_dm     = (m_addr <= DM_END);
  assign in_tc0    = (m_addr >= TC0_BASE) && (m_addr < TC0_BASE + 32'd12);
  assign in_tc1    = (m_addr >= TC1_BASE) && (m_addr < TC1_BASE + 32'd12);
  assign in_int    = (m_addr >= INT_BASE) && (m_addr < INT_BASE + 32'd4);
  assign in_io     = in_tc0 | in_tc1 | in_int;
  assign narrow_io = ~m_size[1] & in_io;
  // Timer COUNT registers are read-only from the CPU side.
  assign count_st  = is_store & ((m_addr[31:2] == TC0_BASE[31:2] + 30'd2) |
                                 (m_addr[31:2] == TC1_BASE[31:2] + 30'd2));
  assign addr_exc  = is_mem & (misalign | ~(in_dm | in_io) | narrow_io | count_st);
  assign access    = is_mem & ~addr_exc & ~req & ~reset;

  always_comb begin
    st_data = m_wdata;
    st_be   = 4'b1111;
    if (!m_size[1]) begin
      if (m_size[0]) begin
        st_data = {2{m_wdata[15:0]}};
        st_be   = m_addr[1] ? 4'b1100 : 4'b0011;
      end else begin
        st_data = {4{m_wdata[7:0]}};
        st_be   = 4'b0001 << m_addr[1:0];
      end
    end
    if (!is_store) st_be = 4'b0000;
  end

`ifdef M_MEM_TIMEOUT_EN
  logic [4:0] tmo_p1;
  logic       timeout;
  assign timeout = (state_q == WAIT) && (tmo_p1 == 5'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d        = state_q;
    latch_en       = 1'b0;
    bus.bus_valid  = 1'b0;
    bus.bus_addr   = {m_addr[31:2], 2'b00};
    bus.bus_wdata  = st_data;
    bus.bus_byteen = 4'b0000;
    m_rdata        = 32'h0;
    m_stall        = 1'b0;
    m_exc          = 1'b0;
    m_exccode      = 5'd0;
    case (state_q)
      IDLE: begin
        if (access) begin
          bus.bus_valid  = 1'b1;
          bus.bus_byteen = st_be;
          if (bus.bus_ready) begin
            if (!is_store) m_rdata = load_extend(bus.bus_rdata, m_addr[1:0], m_size, m_sext);
          end else begin
            m_stall  = 1'b1;
            latch_en = 1'b1;
            state_d  = WAIT;
          end
        end else if (addr_exc && !req && !reset) begin
          m_exc     = 1'b1;
          m_exccode = is_store ? EXC_ADES : EXC_ADEL;
        end
      end
      WAIT: begin
        bus.bus_addr  = addr_p1;
        bus.bus_wdata = wdata_p1;
        // A flush or reset abandons the request outright; the slave sees valid drop.
        if (req || reset) begin
          state_d = IDLE;
`ifdef M_MEM_TIMEOUT_EN
        end else if (timeout) begin
          m_exc     = 1'b1;
          m_exccode = EXC_DBE;
          state_d   = IDLE;
`endif
        end else begin
          bus.bus_valid  = 1'b1;
          bus.bus_byteen = byteen_p1;
          if (bus.bus_ready) begin
            if (load_p1) m_rdata = load_extend(bus.bus_rdata, lane_p1, size_p1, sext_p1);
            state_d = IDLE;
          end else begin
            m_stall = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- p1: request captured on entry to WAIT ----
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_p1   <= 32'h0;
      wdata_p1  <= 32'h0;
      byteen_p1 <= 4'h0;
      lane_p1   <= 2'd0;
      size_p1   <= 2'd0;
      sext_p1   <= 1'b0;
      load_p1   <= 1'b0;
    end else if (latch_en) begin
      addr_p1   <= {m_addr[31:2], 2'b00};
      wdata_p1  <= st_data;
      byteen_p1 <= st_be;
      lane_p1   <= m_addr[1:0];
      size_p1   <= m_size;
      sext_p1   <= m_sext;
      load_p1   <= ~is_store;
    end
  end

`ifdef M_MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset || latch_en)                           tmo_p1 <= 5'd0;
    else if (state_q == WAIT && !bus.bus_ready)      tmo_p1 <= tmo_p1 + 5'd1;
  end
`endif

endmodule

// File: tb/tb_m_mem_unit.sv
// Bench for m_mem_unit: directed vector table, multi-cycle corner sequences and
// randomized transactions checked against a rule-level reference model.
module tb_m_mem_unit;
  logic        clk = 1'b0;
  logic        reset, req, m_load, m_store, m_sext;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_stall, m_exc;
  logic [4:0]  m_exccode;
  int          errors = 0;
  int          checks = 0;

`ifdef M_MEM_TIMEOUT_EN
  localparam int TMO_CYC = 4;
`else
  localparam int TMO_CYC = 16;
`endif

  m_mem_unit_if bus_if();

  m_mem_unit #(.TIMEOUT_CYC(TMO_CYC)) dut (
    .clk(clk), .reset(reset), .req(req), .m_load(m_load), .m_store(m_store),
    .m_size(m_size), .m_sext(m_sext), .m_addr(m_addr), .m_wdata(m_wdata),
    .bus(bus_if), .m_rdata(m_rdata), .m_stall(m_stall), .m_exc(m_exc),
    .m_exccode(m_exccode)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic ld; logic st; logic [1:0] sz; logic sx;
    logic [31:0] a; logic [31:0] d; logic [31:0] rd;
    logic ev; logic [3:0] ebe; logic [31:0] ewd; logic [31:0] erd;
    logic eexc; logic [4:0] ecode;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    m_load = ld; m_store = st; m_size = sz; m_sext = sx; m_addr = a; m_wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    req = 1'b0;
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = 32'h0;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, ".valid"}, 32'(bus_if.bus_valid), 32'd0);
    chk({nm, ".stall"}, 32'(m_stall), 32'd0);
    chk({nm, ".exc"},   32'(m_exc), 32'd0);
  endtask

  // Reference model: derived from the address-map and lane rules directly.
  task automatic model(input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                       output logic exc, output logic [4:0] code, output logic [3:0] be,
                       output logic [31:0] wd, output logic [31:0] rv);
    int n, lane;
    logic dm, io;
    logic [31:0] v;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lane = int'(a[1:0]);
    dm   = (a <= 32'h2FFF);
    io   = (a >= 32'h7F00 && a < 32'h7F0C) || (a >= 32'h7F10 && a < 32'h7F1C) ||
           (a >= 32'h7F20 && a < 32'h7F24);
    exc  = ((lane % n) != 0) || !(dm || io) || (io && n < 4) ||
           (st && (a == 32'h7F08 || a == 32'h7F18));
    code = exc ? (st ? 5'd5 : 5'd4) : 5'd0;
    be   = 4'h0;
    wd   = 32'h0;
    for (int k = 0; k < 4; k++) wd[8*k +: 8] = d[8*(k % n) +: 8];
    if (st && !exc) for (int i = 0; i < n; i++) be[lane + i] = 1'b1;
    v = rd >> (8 * lane);
    for (int b = 8 * n; b < 32; b++) v[b] = sx & v[8*n - 1];
    rv = (st || exc) ? 32'h0 : v;
  endtask

  // One transaction: issue, lat-1 wait cycles, ready on cycle lat, then an idle cycle.
  task automatic run_op(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d, input int lat,
                        input logic [31:0] rd, input logic rq);
    logic exc; logic [4:0] code; logic [3:0] be; logic [31:0] wd, rv;
    model(st, sz, sx, a, d, rd, exc, code, be, wd, rv);
    @(negedge clk);
    drive(ld, st, sz, sx, a, d);
    req = rq;
    bus_if.bus_ready = (lat == 0);
    bus_if.bus_rdata = rd;
    #1;
    if (rq) begin
      chk_quiet("rnd.req");
    end else if (exc) begin
      chk("rnd.exc.valid", 32'(bus_if.bus_valid), 32'd0);
      chk("rnd.exc.stall", 32'(m_stall), 32'd0);
      chk("rnd.exc", 32'(m_exc), 32'd1);
      chk("rnd.exccode", 32'(m_exccode), 32'(code));
    end else begin
      for (int c = 0; c <= lat; c++) begin
        if (c > 0) begin
          @(negedge clk);
          bus_if.bus_ready = (c == lat);
          #1;
        end
        chk("rnd.valid", 32'(bus_if.bus_valid), 32'd1);
        chk("rnd.addr", bus_if.bus_addr, {a[31:2], 2'b00});
        chk("rnd.byteen", 32'(bus_if.bus_byteen), 32'(be));
        if (st) chk("rnd.wdata", bus_if.bus_wdata, wd);
        chk("rnd.stall", 32'(m_stall), 32'(c != lat));
        chk("rnd.exc", 32'(m_exc), 32'd0);
        if (c == lat) chk("rnd.rdata", m_rdata, rv);
      end
    end
    @(negedge clk);
    idle();
    #1;
    chk_quiet("rnd.after");
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sz;
    logic        st, ld;
    int          n;

    tbl[0]  = '{1'b0,1'b1,2'd2,1'b0,32'h0000_0004,32'h1234_5678,32'h0,        1'b1,4'hF,32'h1234_5678,32'h0,        1'b0,5'd0};
    tbl[1]  = '{1'b1,1'b0,2'd0,1'b1,32'h0000_0003,32'h0,        32'h80FF_0000,1'b1,4'h0,32'h0,        32'hFFFF_FF80,1'b0,5'd0};
    tbl[2]  = '{1'b1,1'b0,2'd0,1'b0,32'h0000_0003,32'h0,        32'h80FF_0000,1'b1,4'h0,32'h0,        32'h0000_0080,1'b0,5'd0};
    tbl[3]  = '{1'b0,1'b1,2'd1,1'b0,32'h0000_0002,32'h0000_ABCD,32'h0,        1'b1,4'hC,32'hABCD_ABCD,32'h0,        1'b0,5'd0};
    tbl[4]  = '{1'b1,1'b0,2'd1,1'b1,32'h0000_0001,32'h0,        32'h0,        1'b0,4'h0,32'h0,        32'h0,        1'b1,5'd4};
    tbl[5]  = '{1'b0,1'b1,2'd2,1'b0,32'h0000_7F08,32'h1,        32'h0,        1'b0,4'h0,32'h0,        32'h0,        1'b1,5'd5};
    tbl[6]  = '{1'b0,1'b1,2'd0,1'b0,32'h0000_7F04,32'h1,        32'h0,        1'b0,4'h0,32'h0,        32'h0,        1'b1,5'd5};
    tbl[7]  = '{1'b1,1'b0,2'd2,1'b0,32'h0000_4000,32'h0,        32'h0,        1'b0,4'h0,32'h0,        32'h0,        1'b1,5'd4};
    tbl[8]  = '{1'b1,1'b0,2'd1,1'b1,32'h0000_0002,32'h0,        32'h8001_1234,1'b1,4'h0,32'h0,        32'hFFFF_8001,1'b0,5'd0};
    tbl[9]  = '{1'b1,1'b0,2'd2,1'b0,32'h0000_7F20,32'h0,        32'hDEAD_BEEF,1'b1,4'h0,32'h0,        32'hDEAD_BEEF,1'b0,5'd0};
    tbl[10] = '{1'b0,1'b1,2'd0,1'b0,32'h0000_2FFF,32'h0000_00A5,32'h0,        1'b1,4'h8,32'hA5A5_A5A5,32'h0,        1'b0,5'd0};
    tbl[11] = '{1'b1,1'b0,2'd2,1'b0,32'h0000_3000,32'h0,        32'h0,        1'b0,4'h0,32'h0,        32'h0,        1'b1,5'd4};
    tbl[12] = '{1'b1,1'b0,2'd2,1'b0,32'h0000_7F0C,32'h0,        32'h0,        1'b0,4'h0,32'h0,        32'h0,        1'b1,5'd4};
    tbl[13] = '{1'b0,1'b1,2'd2,1'b0,32'h0000_7F18,32'h5,        32'h0,        1'b0,4'h0,32'h0,        32'h0,        1'b1,5'd5};
    tbl[14] = '{1'b1,1'b0,2'd2,1'b0,32'h0000_7F18,32'h0,        32'h0000_0010,1'b1,4'h0,32'h0,        32'h0000_0010,1'b0,5'd0};
    tbl[15] = '{1'b0,1'b1,2'd3,1'b0,32'h0000_0008,32'h0102_0304,32'h0,        1'b1,4'hF,32'h0102_0304,32'h0,        1'b0,5'd0};
    tbl[16] = '{1'b1,1'b1,2'd2,1'b0,32'h0000_0010,32'h55AA_55AA,32'h1234_5678,1'b1,4'hF,32'h55AA_55AA,32'h0,        1'b0,5'd0};
    tbl[17] = '{1'b0,1'b1,2'd1,1'b0,32'h0000_7F00,32'h1,        32'h0,        1'b0,4'h0,32'h0,        32'h0,        1'b1,5'd5};

    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.valid",  32'(bus_if.bus_valid), 32'd0);
    chk("rst.byteen", 32'(bus_if.bus_byteen), 32'd0);
    chk("rst.stall",  32'(m_stall), 32'd0);
    chk("rst.exc",    32'(m_exc), 32'd0);
    chk("rst.code",   32'(m_exccode), 32'd0);
    chk("rst.rdata",  m_rdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i].ld, tbl[i].st, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].d);
      bus_if.bus_ready = 1'b1;
      bus_if.bus_rdata = tbl[i].rd;
      #1;
      chk($sformatf("v%0d.valid", i),  32'(bus_if.bus_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d.byteen", i), 32'(bus_if.bus_byteen), 32'(tbl[i].ebe));
      if (tbl[i].ev) chk($sformatf("v%0d.addr", i), bus_if.bus_addr, {tbl[i].a[31:2], 2'b00});
      if (tbl[i].ev && tbl[i].st) chk($sformatf("v%0d.wdata", i), bus_if.bus_wdata, tbl[i].ewd);
      chk($sformatf("v%0d.rdata", i), m_rdata, tbl[i].erd);
      chk($sformatf("v%0d.stall", i), 32'(m_stall), 32'd0);
      chk($sformatf("v%0d.exc", i),   32'(m_exc), 32'(tbl[i].eexc));
      chk($sformatf("v%0d.code", i),  32'(m_exccode), 32'(tbl[i].ecode));
      @(negedge clk);
      idle();
      #1;
      chk_quiet($sformatf("v%0d.after", i));
    end

    // Slow load from TC0; request inputs are scrambled while waiting.
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_7F00, 32'h0);
    #1;
    chk("slow.issue.stall", 32'(m_stall), 32'd1);
    chk("slow.issue.valid", 32'(bus_if.bus_valid), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_1235, 32'hFFFF_FFFF);
      if (c == 3) begin
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'hCAFE_F00D;
      end
      #1;
      chk("slow.valid",  32'(bus_if.bus_valid), 32'd1);
      chk("slow.addr",   bus_if.bus_addr, 32'h0000_7F00);
      chk("slow.byteen", 32'(bus_if.bus_byteen), 32'd0);
      chk("slow.stall",  32'(m_stall), 32'(c != 3));
      if (c == 3) chk("slow.rdata", m_rdata, 32'hCAFE_F00D);
    end
    @(negedge clk); idle(); #1;
    chk_quiet("slow.after");

    // Slow halfword store: held lanes must not follow the changed inputs.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0006, 32'h0000_1234);
    #1;
    chk("slowst.stall", 32'(m_stall), 32'd1);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_0099);
      bus_if.bus_ready = (c == 2);
      #1;
      chk("slowst.byteen", 32'(bus_if.bus_byteen), 32'hC);
      chk("slowst.wdata",  bus_if.bus_wdata, 32'h1234_1234);
      chk("slowst.addr",   bus_if.bus_addr, 32'h0000_0004);
      chk("slowst.stall",  32'(m_stall), 32'(c != 2));
    end
    @(negedge clk); idle(); #1;

    // Flush while waiting, then reset while waiting; each followed by a normal access.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_7F04, 32'h0);
      @(negedge clk);
      #1;
      chk("abort.wait.stall", 32'(m_stall), 32'd1);
      @(negedge clk);
      if (k == 0) req = 1'b1; else reset = 1'b1;
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      req = 1'b0; reset = 1'b0;
      #1;
      chk_quiet(k == 0 ? "flush.next" : "reset.next");
      chk("abort.code", 32'(m_exccode), 32'd0);
      run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0BAD_CAFE, 1'b0);
    end

`ifdef M_MEM_TIMEOUT_EN
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_7F00, 32'h0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("tmo.stall", 32'(m_stall), 32'(c < 4));
      chk("tmo.valid", 32'(bus_if.bus_valid), 32'(c < 4));
      chk("tmo.exc",   32'(m_exc), 32'(c == 4));
      chk("tmo.code",  32'(m_exccode), (c == 4) ? 32'd7 : 32'd0);
    end
    @(negedge clk); idle(); #1;
    chk_quiet("tmo.after");
`else
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_7F00, 32'h0);
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("hold.stall", 32'(m_stall), 32'd1);
      chk("hold.valid", 32'(bus_if.bus_valid), 32'd1);
      chk("hold.exc",   32'(m_exc), 32'd0);
    end
    @(negedge clk);
    bus_if.bus_ready = 1'b1;
    bus_if.bus_rdata = 32'h0000_0777;
    #1;
    chk("hold.done.stall", 32'(m_stall), 32'd0);
    chk("hold.done.rdata", m_rdata, 32'h0000_0777);
    @(negedge clk); idle(); #1;
`endif

    for (int t = 0; t < 300; t++) begin
      st = 1'($urandom_range(0, 1));
      ld = st ? 1'($urandom_range(0, 1)) : 1'b1;
      sz = 2'($urandom_range(0, 3));
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      case ($urandom_range(0, 5))
        0, 1:    a = 32'($urandom_range(0, 32'h2FFF));
        2:       a = 32'h7F00 + 32'($urandom_range(0, 11));
        3:       a = 32'h7F10 + 32'($urandom_range(0, 11));
        4:       a = 32'h7F20 + 32'($urandom_range(0, 3));
        default: a = 32'h3000 + 32'($urandom_range(0, 32'h8000));
      endcase
      if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      d = $urandom;
      run_op(ld, st, sz, 1'($urandom_range(0, 1)), a, d, $urandom_range(0, 3), $urandom,
             ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
